// File: rtl/coherence_nc.sv
// N-core coherence front end: round-robin serialisation of L1 read/write requests
// onto one L2 port, with snoop broadcast of op/tag/index to every non-granted L1.
module coherence_nc #(
   parameter int N_CORES = 4,
   parameter int n       = 32,
   parameter int ADDR_W  = 15,
   parameter int TAG_W   = 5,
   parameter int INDEX_W = 6
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_CORES-1:0]          l1_read_request,
   input  logic [N_CORES-1:0]          l1_write_request,
   input  logic [N_CORES*n-1:0]        l1_write_word,
   input  logic [N_CORES*ADDR_W-1:0]   l1_word_address,
   output logic [N_CORES*n-1:0]        l1_read_word,
   output logic [N_CORES-1:0]          l2_busy_out,
   input  logic                        l2_busy_in,
   input  logic [n-1:0]                l2_wdata,
   output logic [n-1:0]                l2_rdata,
   output logic [ADDR_W-1:0]           l2_word_address,
   output logic                        l2_read_request,
   output logic                        l2_write_request,
   output logic [N_CORES-1:0]          others_read_requests,
   output logic [N_CORES-1:0]          others_write_requests,
   output logic [TAG_W-1:0]            others_block_tag,
   output logic [INDEX_W-1:0]          others_block_index
);

   localparam int GW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          grant_q, grant_d;
   logic [GW-1:0]          last_grant_q, last_grant_d;
   logic                   op_write_q, op_write_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [n-1:0]           word_q, word_d;
   logic [N_CORES*n-1:0]   read_word_q, read_word_d;

   logic [N_CORES-1:0]     pending;
   logic [N_CORES-1:0]     grant_oh;
   logic [GW-1:0]          winner;
   logic [GW-1:0]          cand;
   logic                   any_pending;
   logic                   active;

   // Handshake: an L1 holds its request while l2_busy_out[i] is high; the first
   // cycle it sees l2_busy_out[i] low with its request up (the DONE cycle of its
   // own transaction) is the completion strobe, and it must drop or change the
   // request in that cycle or it is arbitrated again as a new transaction.
   assign pending  = l1_read_request | l1_write_request;
   assign grant_oh = N_CORES'(1) << grant_q;
   assign active   = (state_q == ISSUE) || (state_q == WAIT);

   // Walk from farthest to nearest so the nearest pending core after last_grant wins.
   always_comb begin
      winner      = last_grant_q;
      cand        = last_grant_q;
      any_pending = 1'b0;
      for (int k = N_CORES; k >= 1; k--) begin
         cand = GW'((int'(last_grant_q) + k) % N_CORES);
         if (pending[cand]) begin
            winner      = cand;
            any_pending = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      op_write_d   = op_write_q;
      addr_d       = addr_q;
      word_d       = word_q;
      read_word_d  = read_word_q;
      case (state_q)
         IDLE: begin
            if (any_pending) begin
               grant_d    = winner;
               op_write_d = l1_write_request[winner];
               addr_d     = l1_word_address[int'(winner)*ADDR_W +: ADDR_W];
               word_d     = l1_write_request[winner] ? l1_write_word[int'(winner)*n +: n] : '0;
               state_d    = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (!l2_busy_in) begin
               state_d = DONE;
               if (!op_write_q) read_word_d[int'(grant_q)*n +: n] = l2_wdata;
            end
         end
         DONE: begin
            last_grant_d = grant_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(N_CORES - 1);
         op_write_q   <= 1'b0;
         addr_q       <= '0;
         word_q       <= '0;
         read_word_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         op_write_q   <= op_write_d;
         addr_q       <= addr_d;
         word_q       <= word_d;
         read_word_q  <= read_word_d;
      end
   end

   always_comb begin
      l2_read_request       = active & ~op_write_q;
      l2_write_request      = active & op_write_q;
      l2_word_address       = active ? addr_q : '0;
      l2_rdata              = (active && op_write_q) ? word_q : '0;
      others_read_requests  = (active && !op_write_q) ? ~grant_oh : '0;
      others_write_requests = (active && op_write_q) ? ~grant_oh : '0;
      others_block_tag      = active ? addr_q[ADDR_W-1 -: TAG_W] : '0;
      others_block_index    = active ? addr_q[ADDR_W-TAG_W-1 -: INDEX_W] : '0;
      case (state_q)
         IDLE:        l2_busy_out = pending;
         ISSUE, WAIT: l2_busy_out = '1;
         DONE:        l2_busy_out = pending & ~grant_oh;
         default:     l2_busy_out = '0;
      endcase
   end

   assign l1_read_word = read_word_q;

endmodule
